// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field widths, limits, time struct and helpers for the
// real-time-clock slice (rtc_alarm_timer, tick_gen).
package rtc_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;
  localparam logic [MS_W-1:0]   SEC_MAX  = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   min;
    logic [MS_W-1:0]   sec;
  } rtc_time_t;

  // True when every field lies inside its legal time-of-day range.
  function automatic logic time_in_range(input rtc_time_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

  // One-second increment with carry; wrap flags 23:59:59 -> 00:00:00.
  function automatic rtc_time_t time_inc(input rtc_time_t t, output logic wrap);
    rtc_time_t n;
    n    = t;
    wrap = 1'b0;
    if (t.sec == SEC_MAX) begin
      n.sec = '0;
      if (t.min == MIN_MAX) begin
        n.min = '0;
        if (t.hour == HOUR_MAX) begin
          n.hour = '0;
          wrap   = 1'b1;
        end else begin
          n.hour = t.hour + HOUR_W'(1);
        end
      end else begin
        n.min = t.min + MS_W'(1);
      end
    end else begin
      n.sec = t.sec + MS_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_alarm_timer_tick_gen.sv
// tick_gen: prescaler dividing clk_50m down to a one-cycle tick every
// CLK_DIV enabled cycles.
//   clk_50m, rst_n (async, active low)
//   en   : count enable; when low the prescaler holds its value
//   clr  : synchronous restart of the prescaler (valid time load)
//   tick : high in the last cycle of each enabled second
module tick_gen
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_alarm_timer.sv
// rtc_alarm_timer: time-of-day clock (hh:mm:ss) with wrapping uptime,
// synchronous time load, run/pause and one daily alarm.
//   clk_50m, rst_n (async, active low), en (run enable)
//   set_valid/set_hour/set_min/set_sec : load strobe and value
//   set_err   : one-cycle pulse when a load is rejected
//   alarm_en/alarm_hour/alarm_min/alarm_sec : alarm arm and compare time
//   alarm, pps, day_pulse : one-cycle registered pulses
//   hour/min/sec : current time, uptime : seconds since reset
module rtc_alarm_timer
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter int unsigned UPTIME_W = 32
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic                en,
  input  logic                set_valid,
  input  logic [4:0]          set_hour,
  input  logic [5:0]          set_min,
  input  logic [5:0]          set_sec,
  output logic                set_err,
  input  logic                alarm_en,
  input  logic [4:0]          alarm_hour,
  input  logic [5:0]          alarm_min,
  input  logic [5:0]          alarm_sec,
  output logic                alarm,
  output logic [4:0]          hour,
  output logic [5:0]          min,
  output logic [5:0]          sec,
  output logic [UPTIME_W-1:0] uptime,
  output logic                pps,
  output logic                day_pulse
);

  rtc_time_t             time_q, time_d;
  logic [UPTIME_W-1:0]   uptime_q, uptime_d;
  logic                  pps_q, pps_d;
  logic                  alarm_q, alarm_d;
  logic                  day_q, day_d;
  logic                  err_q, err_d;

  rtc_time_t set_time, alarm_time, next_time;
  logic      set_ok, wrap, tick;

  assign set_time   = '{hour: set_hour, min: set_min, sec: set_sec};
  assign alarm_time = '{hour: alarm_hour, min: alarm_min, sec: alarm_sec};
  assign set_ok     = set_valid && time_in_range(set_time);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (set_ok),
    .tick    (tick)
  );

  // Uptime counts every elapsed second even when a load overrides the
  // time; the load only suppresses the time advance and its pulses.
  // The running time is always in range, so an out-of-range alarm
  // compare value can never match.
  always_comb begin
    time_d    = time_q;
    uptime_d  = uptime_q;
    pps_d     = 1'b0;
    alarm_d   = 1'b0;
    day_d     = 1'b0;
    err_d     = set_valid && !set_ok;
    next_time = time_inc(time_q, wrap);

    if (tick) begin
      uptime_d = uptime_q + UPTIME_W'(1);
    end

    if (set_ok) begin
      time_d = set_time;
    end else if (tick) begin
      time_d  = next_time;
      pps_d   = 1'b1;
      day_d   = wrap;
      alarm_d = alarm_en && (next_time == alarm_time);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      time_q   <= '0;
      uptime_q <= '0;
      pps_q    <= 1'b0;
      alarm_q  <= 1'b0;
      day_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      time_q   <= time_d;
      uptime_q <= uptime_d;
      pps_q    <= pps_d;
      alarm_q  <= alarm_d;
      day_q    <= day_d;
      err_q    <= err_d;
    end
  end

  assign hour      = time_q.hour;
  assign min       = time_q.min;
  assign sec       = time_q.sec;
  assign uptime    = uptime_q;
  assign pps       = pps_q;
  assign alarm     = alarm_q;
  assign day_pulse = day_q;
  assign set_err   = err_q;

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Bench for rtc_alarm_timer: seconds-of-day reference model checked every
// cycle, a load-validation vector table, directed corner sequences and
// randomized traffic.
module tb_rtc_alarm_timer;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned UPTIME_W = 8;
  localparam int          UP_MOD   = 1 << UPTIME_W;

  logic                clk_50m = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                set_valid = 1'b0;
  logic [4:0]          set_hour = '0;
  logic [5:0]          set_min = '0;
  logic [5:0]          set_sec = '0;
  logic                set_err;
  logic                alarm_en = 1'b0;
  logic [4:0]          alarm_hour = '0;
  logic [5:0]          alarm_min = '0;
  logic [5:0]          alarm_sec = '0;
  logic                alarm;
  logic [4:0]          hour;
  logic [5:0]          min;
  logic [5:0]          sec;
  logic [UPTIME_W-1:0] uptime;
  logic                pps;
  logic                day_pulse;

  rtc_alarm_timer #(
    .CLK_DIV  (CLK_DIV),
    .UPTIME_W (UPTIME_W)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .en         (en),
    .set_valid  (set_valid),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .set_err    (set_err),
    .alarm_en   (alarm_en),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .alarm      (alarm),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .uptime     (uptime),
    .pps        (pps),
    .day_pulse  (day_pulse)
  );

  always #5 clk_50m = ~clk_50m;

  int tests = 0;
  int fails = 0;

  // Reference model: time of day as seconds since midnight, phase = enabled
  // cycles elapsed in the current second.
  int tod, up_m, phase;
  bit m_pps, m_alarm, m_day, m_err;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tod = 0; up_m = 0; phase = 0;
    m_pps = 0; m_alarm = 0; m_day = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit tick, ok, al_ok;
    int al_tod;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick  = en && (phase == CLK_DIV - 1);
    ok    = set_valid && set_hour <= 23 && set_min <= 59 && set_sec <= 59;
    m_err = set_valid && !ok;
    m_pps = 0; m_alarm = 0; m_day = 0;
    if (tick) up_m = (up_m + 1) % UP_MOD;
    if (ok) begin
      tod   = set_hour * 3600 + set_min * 60 + set_sec;
      phase = 0;
    end else begin
      if (en) phase = tick ? 0 : phase + 1;
      if (tick) begin
        tod    = (tod + 1) % 86400;
        m_pps  = 1;
        m_day  = (tod == 0);
        al_ok  = alarm_hour <= 23 && alarm_min <= 59 && alarm_sec <= 59;
        al_tod = alarm_hour * 3600 + alarm_min * 60 + alarm_sec;
        m_alarm = alarm_en && al_ok && (al_tod == tod);
      end
    end
  endtask

  task automatic compare_all();
    logic [28:0] act, exp;
    act = {hour, min, sec, uptime, pps, alarm, day_pulse, set_err};
    exp = {5'(tod / 3600), 6'((tod / 60) % 60), 6'(tod % 60), 8'(up_m),
           1'(m_pps), 1'(m_alarm), 1'(m_day), 1'(m_err)};
    check("model", act, exp);
  endtask

  task automatic step();
    @(posedge clk_50m);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic load(input int h, input int m, input int s);
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       exp_err;
  } load_vec_t;

  load_vec_t vecs[8];

  initial begin
    int n_pps, n_alarm, u0;

    vecs[0] = '{h: 5'd24, m: 6'd0,  s: 6'd0,  exp_err: 1'b1};
    vecs[1] = '{h: 5'd23, m: 6'd59, s: 6'd59, exp_err: 1'b0};
    vecs[2] = '{h: 5'd0,  m: 6'd60, s: 6'd0,  exp_err: 1'b1};
    vecs[3] = '{h: 5'd0,  m: 6'd0,  s: 6'd60, exp_err: 1'b1};
    vecs[4] = '{h: 5'd31, m: 6'd63, s: 6'd63, exp_err: 1'b1};
    vecs[5] = '{h: 5'd0,  m: 6'd0,  s: 6'd0,  exp_err: 1'b0};
    vecs[6] = '{h: 5'd12, m: 6'd30, s: 6'd45, exp_err: 1'b0};
    vecs[7] = '{h: 5'd7,  m: 6'd59, s: 6'd58, exp_err: 1'b0};

    model_reset();
    #2;
    check("reset_state", {hour, min, sec, uptime, pps, alarm, day_pulse, set_err}, 0);
    #10;
    rst_n = 1'b1;
    en    = 1'b1;

    // Free run: 40 cycles -> 10 seconds.
    n_pps = 0; n_alarm = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_pps += int'(pps);
      n_alarm += int'(alarm);
      if (i == 3) check("first_pps", pps, 1);
    end
    check("run_pps_count", n_pps, 10);
    check("run_sec", sec, 10);
    check("run_uptime", uptime, 10);
    check("run_no_alarm", n_alarm, 0);

    // Midnight rollover.
    load(23, 59, 58);
    u0 = up_m;
    check("load_time", {hour, min, sec}, {5'd23, 6'd59, 6'd58});
    check("load_no_pps", pps, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("roll_pps", pps, (k == 4 || k == 8));
      check("roll_day", day_pulse, (k == 8));
      if (k == 4) check("roll_59", {hour, min, sec}, {5'd23, 6'd59, 6'd59});
      if (k == 8) check("roll_zero", {hour, min, sec}, 0);
    end
    check("roll_uptime", uptime, (u0 + 2) % UP_MOD);

    // Alarm armed.
    alarm_hour = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd5; alarm_en = 1'b1;
    load(0, 0, 3);
    n_alarm = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_alarm += int'(alarm);
      if (k == 8) begin
        check("alarm_fire", {alarm, pps, sec}, {1'b1, 1'b1, 6'd5});
      end
    end
    check("alarm_once", n_alarm, 1);
    // Alarm disarmed.
    alarm_en = 1'b0;
    load(0, 0, 3);
    n_alarm = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_alarm += int'(alarm);
    end
    check("alarm_disarmed", n_alarm, 0);
    // Loading the alarm time itself never fires.
    alarm_en = 1'b1;
    load(0, 0, 5);
    n_alarm = int'(alarm);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_alarm += int'(alarm);
    end
    check("alarm_on_load", n_alarm, 0);
    alarm_en = 1'b0;

    // Invalid load: error pulse, time keeps running.
    set_hour = 5'd1; set_min = 6'd60; set_sec = 6'd0; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    check("bad_load_err", set_err, 1);
    check("bad_load_time", {hour, min, sec}, {5'd0, 6'd0, 6'd6});
    step();
    check("bad_load_err_clear", set_err, 0);

    // Load coincident with tick.
    load(1, 2, 3);
    for (int k = 0; k < 3; k++) step();
    u0 = up_m;
    load(12, 0, 0);
    check("tick_load_time", {hour, min, sec}, {5'd12, 6'd0, 6'd0});
    check("tick_load_no_pps", pps, 0);
    check("tick_load_uptime", uptime, (u0 + 1) % UP_MOD);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("tick_load_next_pps", pps, (k == 4));
    end
    check("tick_load_sec", sec, 1);

    // Pause mid-second.
    load(5, 0, 0);
    step(); step();
    en = 1'b0;
    n_pps = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_pps += int'(pps);
    end
    check("pause_no_pps", n_pps, 0);
    check("pause_sec", sec, 0);
    en = 1'b1;
    step();
    check("resume_pps0", pps, 0);
    step();
    check("resume_pps1", {pps, sec}, {1'b1, 6'd1});

    // Load validation table, spaced so some loads meet a tick.
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].h, vecs[i].m, vecs[i].s);
      check("vec_err", set_err, vecs[i].exp_err);
      if (!vecs[i].exp_err) check("vec_time", {hour, min, sec}, {vecs[i].h, vecs[i].m, vecs[i].s});
      for (int k = 0; k < 1 + i % 4; k++) step();
    end

    // Randomized traffic (long enough for uptime to wrap).
    for (int i = 0; i < 2400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      set_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        set_hour = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(55, 60));
      end else begin
        set_hour = 5'($urandom_range(0, 25));
        set_min  = 6'($urandom_range(0, 61));
        set_sec  = 6'($urandom_range(0, 61));
      end
      if (i % 16 == 0) begin
        u0 = (tod + int'($urandom_range(1, 3))) % 86400;
        alarm_hour = 5'(u0 / 3600);
        alarm_min  = ($urandom_range(0, 9) == 0) ? 6'd60 : 6'((u0 / 60) % 60);
        alarm_sec  = 6'(u0 % 60);
        alarm_en   = ($urandom_range(0, 4) != 0);
      end
      step();
    end
    set_valid = 1'b0;
    en = 1'b1;
    alarm_en = 1'b0;

    // Asynchronous reset mid-run.
    for (int k = 0; k < 6; k++) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", {hour, min, sec, uptime, pps, alarm, day_pulse, set_err}, 0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("post_reset_pps", pps, (k == 4));
    end
    check("post_reset_time", {sec, uptime}, {6'd1, 8'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_timer.md
Name: rtc_alarm_timer

Overview:
- Parametrised successor to the free-running seconds timer.
- Divides the system clock to a 1 Hz tick and keeps time-of-day (hh:mm:ss) plus a wrapping uptime counter.
- Supports synchronous time load, run/pause and one programmable daily alarm.
- Feeds board display, UART status reporting and PPS-aligned logging.

Parameters:
- CLK_DIV, 50_000_000, system clock cycles per second (>= 2); sims override with a small value such as 4.
- UPTIME_W, 32, width of the uptime seconds counter.

Ports:
- clk_50m  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low pauses prescaler and all time registers
- set_valid  in  1  one-cycle strobe to load set_hour/set_min/set_sec
- set_hour  in  5  load value, 0..23
- set_min  in  6  load value, 0..59
- set_sec  in  6  load value, 0..59
- set_err  out  1  one-cycle pulse: load rejected, a field out of range
- alarm_en  in  1  alarm arm
- alarm_hour  in  5  alarm compare hour
- alarm_min  in  6  alarm compare minute
- alarm_sec  in  6  alarm compare second
- alarm  out  1  one-cycle alarm pulse
- hour  out  5  current hour
- min  out  6  current minute
- sec  out  6  current second
- uptime  out  UPTIME_W  seconds since reset, wraps
- pps  out  1  one-cycle pulse per second
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (rst_n low, async): prescaler, hour/min/sec, uptime = 0; pps, alarm, day_pulse, set_err = 0. All outputs are registered.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en = 1; holds while en = 0.
  - tick = (en && prescaler == CLK_DIV-1).
  - Exact period is CLK_DIV cycles, not CLK_DIV+1.
- On tick, at the next clock edge:
  - prescaler <= 0; uptime <= uptime+1, modulo 2^UPTIME_W.
  - sec increments.
  - At 59, sec -> 0 and min increments; at min 59, min -> 0 and hour increments; at hour 23, hour -> 0 and day_pulse = 1.
  - pps = 1 in the same cycle the new time is visible (latency 1 cycle from tick).
- Alarm:
  - Asserts for one cycle, coincident with pps, when alarm_en = 1 and the new (post-increment) time equals alarm_hour:alarm_min:alarm_sec.
  - A load never fires the alarm.
  - Alarm compare values with out-of-range fields simply never match.
- Load:
  - set_valid is sampled every cycle, independent of en.
  - Valid load: hour/min/sec <= set values and prescaler <= 0, so the next pps comes a full CLK_DIV cycles later.
  - A load does not change uptime and does not pulse pps.
  - Invalid load (hour > 23, min > 59 or sec > 59): time is unchanged and set_err = 1 for one cycle. A pending tick still proceeds normally in that case.
- Simultaneous valid load and tick: the load wins. Time = set values, no pps/alarm/day_pulse, uptime still increments, prescaler <= 0.
- en falling mid-second: the prescaler value is retained; counting resumes from it when en returns.
- Pulses (pps, alarm, day_pulse, set_err) are strictly single-cycle and default to 0 every cycle.
- Reset asserted mid-operation clears everything immediately; the first pps after release comes exactly CLK_DIV cycles after the first enabled edge.

Decomposition:
- Shared package rtc_pkg:
  - constants SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23
  - field widths HOUR_W = 5, MS_W = 6
  - a time struct typedef {hour, min, sec}, used by the time registers, set inputs and alarm compare.
- Sub-module tick_gen:
  - Parameter CLK_DIV; inputs clk_50m, rst_n, en, clr.
  - Output tick.
  - Owns the prescaler; clr is driven by a valid load.
- Top level holds the time/uptime registers, load validation and alarm compare.

Test Plan:
1. Reset, CLK_DIV = 4, en = 1 for 40 cycles -> pps every 4 cycles; sec counts 1..10; uptime = 10; no alarm.
2. Load 23:59:58, run 2 seconds -> 23:59:59, then 00:00:00 with day_pulse = 1 and pps = 1 in the same cycle; uptime += 2.
3. Alarm 00:00:05 with alarm_en = 1, load 00:00:03 -> alarm pulses once, with pps, when sec becomes 5. With alarm_en = 0 there is no pulse. Loading 00:00:05 directly gives no pulse.
4. set_valid with set_min = 60 -> set_err for 1 cycle; time is unchanged and continues counting.
5. set_valid asserted on the tick cycle with value 12:00:00 -> time = 12:00:00, no pps, uptime +1; next pps arrives 4 cycles later.
6. en low for 10 cycles mid-second, then high -> no pps while paused; the remaining prescaler count completes. Async rst_n pulse mid-run -> all outputs 0 immediately.
